// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester front-end arbiter:
// op codes, the legal-op count and the arbiter FSM state encoding.
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int OP_W    = 4;
    localparam int NUM_OPS = 10;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

    // Op codes at or above num_ops are reported back as errors, never executed.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op, input int num_ops);
        logic [31:0] op_ext;
        op_ext = {{(32-OP_W){1'b0}}, op};
        return (op_ext < 32'(num_ops));
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = ~last_grant;
        if (req[0] && !req[1]) begin
            grant = 1'b0;
        end else if (req[1] && !req[0]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters, one op in flight at a
// time: IDLE accepts, EXEC pulses the ALU capture enable, RESP holds the result.
module alu_arbiter #(
    parameter int NUM_OPS = alu_pkg::NUM_OPS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op_select,
    output logic        alu_clk_enable,
    input  logic [31:0] alu_out
);
    import alu_pkg::*;

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              id_q, id_d;
    logic              err_q, err_d;

    logic              grant;
    logic              sel_valid;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [OP_W-1:0]   sel_op;
    logic              accept;

    rr_arbiter_2 u_rr (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        sel_valid = grant ? req1_valid : req0_valid;
        sel_a     = grant ? req1_a     : req0_a;
        sel_b     = grant ? req1_b     : req0_b;
        sel_op    = grant ? req1_op    : req0_op;
        accept    = (state_q == ST_IDLE) && sel_valid;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d          = sel_a;
                    b_d          = sel_b;
                    op_d         = sel_op;
                    id_d         = grant;
                    last_grant_d = grant;
                    // Illegal ops skip the ALU and report an error directly.
                    if (op_is_legal(sel_op, NUM_OPS)) begin
                        err_d   = 1'b0;
                        state_d = ST_EXEC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            err_q        <= err_d;
        end
    end

    assign req0_ready     = (state_q == ST_IDLE) && !grant;
    assign req1_ready     = (state_q == ST_IDLE) &&  grant;

    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign alu_op_select  = op_q;
    assign alu_clk_enable = (state_q == ST_EXEC);

    assign resp_valid     = (state_q == ST_RESP);
    assign resp_id        = id_q;
    assign resp_err       = (state_q == ST_RESP) && err_q;
    assign resp_data      = err_q ? '0 : alu_out;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU attached
// to the shared-ALU port; expected values are hand-computed constants.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [3:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [3:0]  req1_op;
    logic        resp_valid, resp_ready, resp_id, resp_err;
    logic [31:0] resp_data;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op_select;
    logic        alu_clk_enable;
    logic [31:0] alu_out = 32'd0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_a         (req0_a),
        .req0_b         (req0_b),
        .req0_op        (req0_op),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_a         (req1_a),
        .req1_b         (req1_b),
        .req1_op        (req1_op),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_op_select  (alu_op_select),
        .alu_clk_enable (alu_clk_enable),
        .alu_out        (alu_out)
    );

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        logic [31:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << b[4:0];
            4'd6:    r = a >> b[4:0];
            4'd7:    r = {31'd0, ($signed(a) < $signed(b))};
            4'd8:    r = {31'd0, (a < b)};
            4'd9:    r = $signed(a) >>> b[4:0];
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Shared ALU: result registered on the capture enable.
    always @(posedge clk) begin
        if (alu_clk_enable) alu_out <= alu_f(alu_a, alu_b, alu_op_select);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_alu_en",     32'(alu_clk_enable), 32'd0);
        chk("rst_resp_id",    32'(resp_id), 32'd0);
        chk("rst_resp_err",   32'(resp_err), 32'd0);
        chk("rst_alu_a",      alu_a, 32'd0);
        chk("rst_alu_op",     32'(alu_op_select), 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd1);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        rst = 1'b0;

        // Single ADD from requester 0
        tick();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 4'd0;
        resp_ready = 1'b1;
        #1;
        chk("add_req0_ready", 32'(req0_ready), 32'd1);
        chk("add_req1_ready", 32'(req1_ready), 32'd0);
        chk("add_en_t",       32'(alu_clk_enable), 32'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("add_en_t1",      32'(alu_clk_enable), 32'd1);
        chk("add_alu_a",      alu_a, 32'd5);
        chk("add_alu_b",      alu_b, 32'd7);
        chk("add_alu_op",     32'(alu_op_select), 32'd0);
        chk("add_vld_t1",     32'(resp_valid), 32'd0);
        chk("add_ready_t1",   32'(req0_ready), 32'd0);
        tick();
        #1;
        chk("add_vld_t2",     32'(resp_valid), 32'd1);
        chk("add_data",       resp_data, 32'd12);
        chk("add_id",         32'(resp_id), 32'd0);
        chk("add_err",        32'(resp_err), 32'd0);
        chk("add_en_t2",      32'(alu_clk_enable), 32'd0);
        tick();
        #1;
        chk("add_vld_t3",     32'(resp_valid), 32'd0);

        // Illegal op from requester 1
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_op = 4'b1100;
        #1;
        chk("ill_req1_ready", 32'(req1_ready), 32'd1);
        chk("ill_req0_ready", 32'(req0_ready), 32'd0);
        tick();
        req1_valid = 1'b0;
        #1;
        chk("ill_vld_t1",     32'(resp_valid), 32'd1);
        chk("ill_err",        32'(resp_err), 32'd1);
        chk("ill_data",       resp_data, 32'd0);
        chk("ill_id",         32'(resp_id), 32'd1);
        chk("ill_en",         32'(alu_clk_enable), 32'd0);
        tick();
        #1;
        chk("ill_vld_after",  32'(resp_valid), 32'd0);
        chk("ill_err_after",  32'(resp_err), 32'd0);
        chk("ill_en_after",   32'(alu_clk_enable), 32'd0);

        // Contention: both valid continuously, grants alternate 0,1,0,1
        req0_valid = 1'b1; req0_a = 32'd10;  req0_b = 32'd3;  req0_op = 4'd1;
        req1_valid = 1'b1; req1_a = 32'hF0;  req1_b = 32'h0F; req1_op = 4'd4;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready0", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", 32'(req1_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            #1;
            chk("rr_en",     32'(alu_clk_enable), 32'd1);
            tick();
            #1;
            chk("rr_vld",    32'(resp_valid), 32'd1);
            chk("rr_id",     32'(resp_id), (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr_data",   resp_data, (k % 2 == 0) ? 32'd7 : 32'hFF);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure: result held for 5 cycles with resp_ready low
        req0_valid = 1'b1; req0_a = 32'h10; req0_b = 32'h20; req0_op = 4'd0;
        req1_valid = 1'b1;
        resp_ready = 1'b0;
        #1;
        chk("bp_req0_ready", 32'(req0_ready), 32'd1);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_vld",    32'(resp_valid), 32'd1);
            chk("bp_data",   resp_data, 32'h30);
            chk("bp_id",     32'(resp_id), 32'd0);
            chk("bp_ready0", 32'(req0_ready), 32'd0);
            chk("bp_ready1", 32'(req1_ready), 32'd0);
            chk("bp_en",     32'(alu_clk_enable), 32'd0);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("bp_vld_release", 32'(resp_valid), 32'd1);
        chk("bp_data_release", resp_data, 32'h30);
        tick();
        #1;
        chk("bp_vld_done",   32'(resp_valid), 32'd0);

        // Reset while in EXEC drops the op
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 4'd0;
        tick();
        req1_valid = 1'b0;
        #1;
        chk("rx_en_exec",    32'(alu_clk_enable), 32'd1);
        rst = 1'b1;
        tick();
        #1;
        chk("rx_vld",        32'(resp_valid), 32'd0);
        chk("rx_en",         32'(alu_clk_enable), 32'd0);
        chk("rx_alu_a",      alu_a, 32'd0);
        chk("rx_idle_ready", 32'(req0_ready), 32'd1);
        rst = 1'b0;
        tick();
        #1;
        chk("rx_no_resp1",   32'(resp_valid), 32'd0);
        tick();
        #1;
        chk("rx_no_resp2",   32'(resp_valid), 32'd0);

        // First tie after reset goes to requester 0; SRA result forwarded as-is
        req0_valid = 1'b1; req0_a = 32'h8000_0000; req0_b = 32'd4; req0_op = 4'b1001;
        req1_valid = 1'b1; req1_a = 32'd1;         req1_b = 32'd1; req1_op = 4'd0;
        #1;
        chk("sra_req0_ready", 32'(req0_ready), 32'd1);
        chk("sra_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        #1;
        chk("sra_vld",  32'(resp_valid), 32'd1);
        chk("sra_data", resp_data, 32'hF800_0000);
        chk("sra_id",   32'(resp_id), 32'd0);
        chk("sra_err",  32'(resp_err), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: synchronous, active-high; clock port clk, reset port rst.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_a / req0_b  in  32  requester 0 operands
- req0_op  in  4  requester 0 ALU op code
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_id  out  1  requester index owning the result
- resp_data  out  32  result
- resp_err  out  1  op code was illegal (>4'b1001)
- alu_a / alu_b  out  32  operands to the shared ALU
- alu_op_select  out  4  op to the shared ALU
- alu_clk_enable  out  1  ALU capture enable
- alu_out  in  32  registered ALU result
REQ-003 SHALL have parameter NUM_OPS, default 10, meaning count of legal op codes (0..NUM_OPS-1).

Function
REQ-004 SHALL implement FSM states IDLE, EXEC, RESP; one op outstanding at a time.
REQ-005 IDLE: grant SHALL be combinational; only one valid -> grant it; both valid -> grant the requester not granted last; req<g>_ready = (state==IDLE) && grant==g; other ready low.
REQ-006 Accept = req<g>_valid && req<g>_ready at an edge; SHALL latch a, b, op, id=g and update last_grant=g.
REQ-007 Accepted legal op: IDLE -> EXEC; illegal op (op >= NUM_OPS): IDLE -> RESP with resp_err=1, resp_data=0, ALU not enabled.
REQ-008 EXEC (exactly one cycle): alu_clk_enable=1, alu_a/alu_b/alu_op_select driven from latched regs; next state RESP.
REQ-009 alu_clk_enable SHALL be 0 in every state other than EXEC; alu_a/alu_b/alu_op_select SHALL always reflect latched regs.
REQ-010 RESP: resp_valid=1, resp_id=latched id, resp_data=alu_out (legal) or 0 (illegal), resp_err as latched; outputs stable until handshake.
REQ-011 resp_valid && resp_ready -> IDLE; no new accept in that same cycle (ready only in IDLE).
REQ-012 Latency: accept in cycle t -> resp_valid high in cycle t+2 (legal), t+1 (illegal); min throughput one op per 3 cycles.
REQ-013 Requesters SHALL hold valid and payload stable until ready; deasserting valid without accept SHALL be permitted and have no effect.
REQ-014 Round-robin SHALL be starvation-free: with both valid continuously, grants alternate 0,1,0,1.
REQ-015 resp_ready held high in RESP SHALL complete in one cycle; low SHALL stall indefinitely with all outputs held.

Reset
REQ-016 rst SHALL force, from the next cycle: state=IDLE, last_grant=1 (requester 0 wins first tie), resp_valid=0, resp_err=0, resp_id=0, alu_clk_enable=0, latched a/b/op=0.
REQ-017 rst during EXEC or RESP SHALL drop the in-flight op with no response; rst has priority over any handshake in the same cycle.

Structure
REQ-018 alu_pkg SHALL hold the ALU op enum (ADD..SRA, 4'b0000..4'b1001), NUM_OPS constant, and the arbiter state enum; shared with the ALU.
REQ-019 Grant logic SHALL be a sub-module rr_arbiter_2 (inputs req[1:0], last_grant; output grant).

Verification
REQ-020 Single op: req0 ADD a=5 b=7 accepted cycle t, resp_ready=1 -> resp_valid cycle t+2, resp_data=12, resp_id=0, resp_err=0, alu_clk_enable high only in t+1.
REQ-021 Contention: both valid continuously, req0 SUB 10-3, req1 XOR 0xF0^0x0F -> responses id 0 (7) then id 1 (0xFF), then alternating.
REQ-022 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid/data/id stable, both req*_ready low, ALU not re-enabled.
REQ-023 Illegal op: req1 op=4'b1100 -> resp_valid cycle t+1, resp_err=1, resp_data=0, alu_clk_enable never high.
REQ-024 Reset in EXEC: rst asserted in EXEC -> next cycle IDLE, resp_valid=0, no response for dropped op; next tie grants requester 0.
REQ-025 SRA check: req0 a=0x80000000 b=4 op=4'b1001 -> resp_data as ALU returns for that op, forwarded unchanged, resp_id=0.
